// File: rtl/score_disp_pkg.sv
// score_disp_pkg
// Shared definitions for the score-to-seven-segment display path.
//   - seven-segment lookup constants (active-low, dp = bit 7 held high)
//   - conversion FSM state type
//   - pow10() helper used to build the saturation threshold
//   - seg7() digit-to-segment decoder
package score_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } disp_state_e;

  // 10^n as a 64-bit value; only ever evaluated on constants (n <= 8).
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   start      - one-cycle pulse: load din and begin WIDTH iterations
//   din        - unsigned binary input, sampled on start
//   bcd        - low DIGITS nibbles of the result (valid while !busy after done)
//   busy       - high while iterations remain
//   done       - one-cycle pulse in the cycle after the final iteration
// The accumulator carries one spare nibble above DIGITS. Digits only ever
// carry upward, so whatever piles up in or beyond that nibble for
// out-of-range inputs cannot disturb the low DIGITS nibbles.
module bin2bcd_dd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int BW    = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [BW-1:0]       bcd_q;
  logic [WIDTH-1:0]    bin_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;

  // Add-3 correction on every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_q <= din;
        bcd_q <= '0;
        cnt_q <= CNT_W'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        {bcd_q, bin_q} <= shifted;
        cnt_q          <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = bcd_q[DIGITS*4-1:0];

endmodule

// File: rtl/score_display_seq.sv
// score_display_seq
// Captures a binary score, converts it to BCD over several cycles,
// saturates values that do not fit in DIGITS decimal digits, and scans
// the digits onto a shared active-low seven-segment bus.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   i_score       - unsigned score, only looked at while idle
//   o_busy        - high from the capture edge until the display update
//   o_overflow    - high while the displayed value is saturated (all 9s)
//   o_segment     - registered active-low segments {dp, g..a}; dp held at 1
//   o_segment_an  - registered active-low one-hot digit select
// Optional build macro:
//   SCORE_LZ_BLANK_EN - blank leading zeros (digit 0 is always shown)
//
// Handshake: there is none on the input; a conversion starts whenever the
// idle FSM sees i_score differ from the last captured value, and any change
// during SHIFT/DONE is picked up on the first idle cycle afterwards.
module score_display_seq
  import score_disp_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_score,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [7:0]        o_segment,
  output logic [DIGITS-1:0] o_segment_an
);

  localparam int              SCAN_W    = $clog2(SCAN_DIV);
  localparam int              IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0]     OVF_LIMIT = pow10(DIGITS);
  localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

  disp_state_e state_q, state_d;

  logic [WIDTH-1:0]    score_q;
  logic                ovf_pend;
  logic                is_ovf;
  logic                start;
  logic                load_disp;
  logic [DIGITS*4-1:0] eng_bcd;
  logic                eng_busy;
  logic                eng_done;
  logic [DIGITS*4-1:0] disp_q;
  logic [DIGITS*4-1:0] disp_nxt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [3:0]          cur_nib;
  logic [7:0]          seg_nxt;

  // When 10^DIGITS is beyond the WIDTH-bit range this is constant false.
  assign is_ovf = (64'(i_score) >= OVF_LIMIT);

  bin2bcd_dd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (i_score),
    .bcd   (eng_bcd),
    .busy  (eng_busy),
    .done  (eng_done)
  );

  // Conversion FSM: next state and strobes.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    load_disp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_score != score_q) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (eng_done && !eng_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        load_disp = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_nxt = ovf_pend ? {DIGITS{4'h9}} : eng_bcd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      ovf_pend   <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        score_q  <= i_score;
        ovf_pend <= is_ovf;
        o_busy   <= 1'b1;
      end
      if (load_disp) begin
        disp_q     <= disp_nxt;
        o_overflow <= ovf_pend;
        o_busy     <= 1'b0;
      end
    end
  end

`ifdef SCORE_LZ_BLANK_EN
  // Blank mask travels with the display register so both change together.
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;

  always_comb begin
    logic seen_nz;
    seen_nz   = 1'b0;
    blank_nxt = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz      = seen_nz | (disp_nxt[i*4 +: 4] != 4'd0);
      blank_nxt[i] = ~seen_nz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= ~ONE_HOT0;
    end else if (load_disp) begin
      blank_q <= blank_nxt;
    end
  end
`endif

  // Digit scan, free-running and independent of conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (dig_idx == IDX_W'(DIGITS - 1)) begin
        dig_idx <= '0;
      end else begin
        dig_idx <= dig_idx + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign cur_nib = disp_q[dig_idx*4 +: 4];

  always_comb begin
    seg_nxt = seg7(cur_nib);
`ifdef SCORE_LZ_BLANK_EN
    if (blank_q[dig_idx]) begin
      seg_nxt = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_segment    <= SEG_0;
      o_segment_an <= ~ONE_HOT0;
    end else begin
      o_segment    <= seg_nxt;
      o_segment_an <= ~(ONE_HOT0 << dig_idx);
    end
  end

endmodule

// File: tb/tb_score_display_seq.sv
// tb_score_display_seq
// Bench for score_display_seq with WIDTH=14, DIGITS=4, SCAN_DIV=4.
// Stimulus pushes the expected display (overflow flag plus the segment
// pattern of every digit) when a score is applied; a monitor waits for each
// completed conversion, watches one full scan period and compares.
// Honours SCORE_LZ_BLANK_EN in its reference model.
module tb_score_display_seq;

  localparam int W  = 14;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int EW = D * 8 + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] i_score;
  logic         o_busy;
  logic         o_overflow;
  logic [7:0]   o_segment;
  logic [D-1:0] o_segment_an;

  logic [EW-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  int mon_done;
  int done_target;
  logic [W-1:0] last_score;

  score_display_seq #(
    .WIDTH    (W),
    .DIGITS   (D),
    .SCAN_DIV (SD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_score      (i_score),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_segment    (o_segment),
    .o_segment_an (o_segment_an)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  // Reference: decimal digits via division, saturation to 10^D-1.
  function automatic logic [EW-1:0] model(input longint unsigned v);
    longint unsigned lim;
    longint unsigned shown;
    longint unsigned p;
    logic [EW-1:0] r;
    logic [7:0] s;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    r = '0;
    r[EW-1] = (v >= lim);
    shown = (v >= lim) ? lim - 1 : v;
    p = 1;
    for (int i = 0; i < D; i++) begin
      s = seg_of(int'((shown / p) % 10));
`ifdef SCORE_LZ_BLANK_EN
      if (i > 0 && shown < p) s = 8'hFF;
`endif
      r[i*8 +: 8] = s;
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    i_score = v;
    last_score = v;
    exp_q.push_back(model(longint'(v)));
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (mon_done < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("conversion_timeout", 64'(mon_done >= target), 64'd1);
  endtask

  task automatic run_one(input logic [W-1:0] v);
    apply(v);
    done_target++;
    wait_done(done_target);
  endtask

  // ---------------- busy-length checker ----------------
  initial begin : busy_len
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else if (o_busy) begin
        run++;
      end else if (run > 0) begin
        check("busy_cycles", 64'(run), 64'(W + 2));
        run = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          prev_busy;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    logic [D-1:0]  sel;
    int cnt [D];
    int bad_an, bad_ord, bad_hold, last_k, k;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else if (prev_busy && !o_busy) begin
        // Display register loaded on this edge; segments follow one edge later.
        @(negedge clk);
        got = '0;
        bad_an = 0;
        bad_ord = 0;
        bad_hold = 0;
        last_k = -1;
        for (int i = 0; i < D; i++) cnt[i] = 0;
        got[EW-1] = o_overflow;
        for (int s = 0; s < D * SD; s++) begin
          if (s > 0) @(negedge clk);
          k = -1;
          for (int i = 0; i < D; i++) begin
            sel = '0;
            sel[i] = 1'b1;
            if (o_segment_an == ~sel) k = i;
          end
          if (k < 0) begin
            bad_an++;
          end else begin
            got[k*8 +: 8] = o_segment;
            cnt[k]++;
            if (last_k >= 0 && k != last_k && k != (last_k + 1) % D) bad_ord++;
            last_k = k;
          end
        end
        for (int i = 0; i < D; i++) if (cnt[i] != SD) bad_hold++;
        check("scan_anode_onehot", 64'(bad_an), 64'd0);
        check("scan_order", 64'(bad_ord), 64'd0);
        check("scan_hold", 64'(bad_hold), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL display: got %h expected nothing (queue empty)", got);
        end else begin
          exp = exp_q.pop_front();
          check("display", 64'(got), 64'(exp));
        end
        mon_done++;
        prev_busy = o_busy;
      end else begin
        prev_busy = o_busy;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin : stimulus
    logic [W-1:0] v;
    n_cmp = 0;
    n_err = 0;
    mon_done = 0;
    done_target = 0;
    last_score = '0;
    rst = 1'b1;
    i_score = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_anode", 64'(o_segment_an), 64'(4'hE));
    check("reset_segment", 64'(o_segment), 64'h00C0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_overflow", 64'(o_overflow), 64'd0);

    // Directed values from the test plan.
    run_one(14'd1234);
    run_one(14'd12000);
    run_one(14'd9999);
    run_one(14'd10000);

    // Change during SHIFT: first result stands, second follows.
    apply(14'd50);
    repeat (5) @(posedge clk);
    apply(14'd51);
    done_target += 2;
    wait_done(done_target);

    run_one(14'd7);
    run_one(14'd0);
    run_one(14'd1);

    // Randomized scores across small, full-range, boundary and overflow bands.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: v = W'($urandom_range(0, 99));
        1: v = W'($urandom_range(0, 9999));
        2: v = W'($urandom_range(9990, 10010));
        default: v = W'($urandom_range(10000, 16383));
      endcase
      if (v == last_score) v = v + 1'b1;
      run_one(v);
    end

    // Reset in the middle of a conversion.
    if (last_score == 14'd999) run_one(14'd5);
    apply(14'd999);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_segment", 64'(o_segment), 64'h00C0);
    check("midreset_anode", 64'(o_segment_an), 64'(4'hE));
    check("midreset_busy", 64'(o_busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    done_target++;
    wait_done(done_target);

    repeat (4) @(posedge clk);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display_seq.md
# score_display_seq

Parametrised, fully sequential score-to-seven-segment driver. Captures a binary score, converts it to BCD with a multi-cycle double-dabble engine, saturates values beyond the digit range and time-multiplexes `DIGITS` digits onto a shared active-low segment bus. It sits between the game-logic score counter and the board's seven-segment pins, and replaces the fixed 4-digit divide/modulo display path.

## Interface
- `WIDTH`, 14: binary score width; legal range 4..32.
- `DIGITS`, 4: number of displayed decimal digits; legal range 1..8.
- `SCAN_DIV`, 100000: clock cycles each digit stays selected; must be ≥2.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_score` in WIDTH: unsigned binary score; sampled only in IDLE.
- `o_busy` out 1: high while a conversion is in progress.
- `o_overflow` out 1: high while the displayed value is saturated.
- `o_segment` out 8: active-low segments, with `[6:0]` = g..a and `[7]` = dp. The dp bit is held at 1.
- `o_segment_an` out DIGITS: active-low one-hot digit select.

## Operation
- Conversion FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:**
  - If `i_score` ≠ the captured register, capture `i_score` and go to SHIFT.
  - Also in that cycle, set `o_busy=1` and `ovf_pend = (i_score ≥ 10^DIGITS)`.
- **SHIFT:**
  - Runs exactly WIDTH iterations, one per cycle.
  - Each iteration adds 3 to every BCD nibble that is ≥5, then shifts {bcd, bin} left by one.
  - The BCD accumulator is DIGITS+1 nibbles wide so that overflow values never corrupt the low digits.
  - After the last iteration, go to DONE.
- **DONE:**
  - Atomically load the display register with the accumulator, or with all nibbles = 9 if `ovf_pend` is set.
  - Load `o_overflow` from `ovf_pend`, clear `o_busy`, and return to IDLE.
- Score changes while SHIFT or DONE is active are ignored. The IDLE comparison picks up the latest value on the cycle after DONE.
- **Scan:**
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - On wrap, `dig_idx` increments and wraps from DIGITS-1 to 0.
  - Conversion does not affect scanning.
- Segment encoding for digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Nibbles above 9 cannot occur.

## Timing
- **Reset:**
  - State=IDLE, captured score=0, display register=0.
  - `scan_cnt`=0, `dig_idx`=0, `o_busy`=0, `o_overflow`=0.
  - `o_segment_an` = ~1 (digit 0 selected), `o_segment`=8'hC0.
- **Conversion latency:** the new value is in the display register WIDTH+2 cycles after the capture edge.
  - Capture takes 1 cycle, SHIFT takes WIDTH cycles, DONE takes 1 cycle.
- **Outputs:** `o_segment` and `o_segment_an` are registered.
  - They reflect `dig_idx` and the display register one cycle after either changes.
- **Reset mid-conversion:** the conversion is aborted and the display shows "0" on the next cycle.
  - If `i_score` ≠ 0, a new capture occurs on the first cycle after reset is released.
- **Maximum value:** a value exactly equal to 10^DIGITS-1 is not overflow. 10^DIGITS is overflow.
- **10^DIGITS wider than WIDTH:** when 10^DIGITS exceeds the WIDTH-bit range, the overflow comparison is constant 0 and `o_overflow` never asserts.

## Configuration
- `SCORE_LZ_BLANK_EN` defined: leading zeros are blanked.
  - Any digit above the most significant non-zero digit drives `o_segment`=8'hFF, with its anode still scanned.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - The blank mask is computed from the display register in DONE and takes effect with the same registered update.
- Undefined: all DIGITS digits are always shown, including leading zeros.

## Structure
- Package `score_disp_pkg` holds:
  - the seg7 lookup constants (0–9 and BLANK=8'hFF);
  - FSM state typedef (IDLE/SHIFT/DONE);
  - helper function `pow10(n)` used for the overflow threshold.
- Sub-module `bin2bcd_dd` is the natural split.
  - It contains the iterative double-dabble engine with start/busy/done and is parametrised by WIDTH and DIGITS.
  - The top level contains capture, saturation, display register, scan counter and output registers.

## Test plan
- **Reset:** assert `rst` for 2 cycles.
  - `o_segment_an`=~1, `o_segment`=8'hC0, `o_busy`=0 and `o_overflow`=0 on the first cycle after release while `i_score`=0.
- **Conversion, WIDTH=14, DIGITS=4, SCAN_DIV=4:** apply `i_score`=1234.
  - `o_busy` is high for 16 cycles.
  - Then the scan shows digits 4, 3, 2, 1, i.e. segments 99, B0, A4, F9 with anodes E, D, B, 7, each for 4 cycles, and wraps back to digit 0.
- **Overflow:** apply `i_score`=12000.
  - All digits show 90 and `o_overflow`=1.
  - Then apply 9999: same digits, `o_overflow`=0.
- **Change mid-conversion:** apply 50, then change to 51 during SHIFT.
  - The display shows 0050 first.
  - A second conversion starts the cycle after DONE and the display ends at 0051.
- **SCORE_LZ_BLANK_EN defined:** apply `i_score`=7.
  - Digit 0 = F8 and digits 1–3 = FF.
  - Then apply `i_score`=0: digit 0 = C0 and the others = FF.
- **Reset mid-SHIFT:** assert reset during conversion of 999.
  - The display returns to 0.
  - After release, recapture completes and shows 0999 in WIDTH+2 cycles.
